// File: rtl/uart_rom_loader.sv
// uart_rom_loader: boot loader from an 8N1 UART into instruction ROM.
// Receives a 16-bit little-endian word count followed by little-endian
// 32-bit words, writes each word to ROM and then releases the CPU.
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high reset
//   uart_rx    asynchronous serial input, idle high
//   rom_we     one-cycle ROM write strobe
//   rom_waddr  word-aligned byte address of the write
//   rom_wdata  word written
//   cpu_enable high once the whole image is in ROM, sticky until reset
//   busy       image reception in progress
//   error      sticky framing / oversize-length error
module uart_rom_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int MAX_WORDS    = 2048,
  parameter int ADDR_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_CNT =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_LEN0,
    L_LEN1,
    L_DATA,
    L_DONE,
    L_ERROR
  } ld_state_t;

  // ---------------- synchroniser ----------------
  logic r_rx_meta;
  logic r_rx_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t        r_rx_state;
  rx_state_t        w_rx_next;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [CNT_W-1:0] w_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [2:0]       w_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift;
  logic             w_byte_valid;
  logic             w_frame_err;
  logic             w_half_tick;
  logic             w_bit_tick;

  assign w_half_tick = (r_clk_cnt == HALF_CNT);
  assign w_bit_tick  = (r_clk_cnt == FULL_CNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_state <= R_IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      r_clk_cnt  <= w_clk_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_shift    <= w_shift;
    end
  end

  always_comb begin
    w_rx_next    = r_rx_state;
    w_clk_cnt    = r_clk_cnt + 1'b1;
    w_bit_cnt    = r_bit_cnt;
    w_shift      = r_shift;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    unique case (r_rx_state)
      R_IDLE: begin
        w_clk_cnt = '0;
        if (!r_rx_sync) begin
          w_rx_next = R_START;
          w_bit_cnt = '0;
        end
      end
      R_START: begin
        // Re-check mid start bit; a high level means a glitch.
        if (w_half_tick) begin
          w_clk_cnt = '0;
          w_rx_next = r_rx_sync ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (w_bit_tick) begin
          w_clk_cnt = '0;
          w_shift   = {r_rx_sync, r_shift[7:1]};
          w_bit_cnt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_rx_next = R_STOP;
          end
        end
      end
      R_STOP: begin
        if (w_bit_tick) begin
          w_clk_cnt = '0;
          w_rx_next = R_IDLE;
          if (r_rx_sync) begin
            w_byte_valid = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end
      end
      default: begin
        w_rx_next = R_IDLE;
      end
    endcase
  end

  // ---------------- image loader ----------------
  ld_state_t         r_ld_state;
  ld_state_t         w_ld_next;
  logic [15:0]       r_len;
  logic [15:0]       w_len;
  logic [15:0]       w_len_full;
  logic [15:0]       r_word_idx;
  logic [15:0]       w_word_idx;
  logic [1:0]        r_byte_idx;
  logic [1:0]        w_byte_idx;
  logic [23:0]       r_word;
  logic [23:0]       w_word;
  logic              r_we;
  logic              w_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       r_wdata;
  logic [31:0]       w_wdata;

  assign w_len_full = {r_shift, r_len[7:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ld_state <= L_LEN0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_ld_state <= w_ld_next;
      r_len      <= w_len;
      r_word_idx <= w_word_idx;
      r_byte_idx <= w_byte_idx;
      r_word     <= w_word;
      r_we       <= w_we;
      r_waddr    <= w_waddr;
      r_wdata    <= w_wdata;
    end
  end

  always_comb begin
    w_ld_next  = r_ld_state;
    w_len      = r_len;
    w_word_idx = r_word_idx;
    w_byte_idx = r_byte_idx;
    w_word     = r_word;
    w_we       = 1'b0;
    w_waddr    = r_waddr;
    w_wdata    = r_wdata;
    unique case (r_ld_state)
      L_LEN0: begin
        if (w_frame_err) begin
          w_ld_next = L_ERROR;
        end else if (w_byte_valid) begin
          w_len     = {8'h00, r_shift};
          w_ld_next = L_LEN1;
        end
      end
      L_LEN1: begin
        if (w_frame_err) begin
          w_ld_next = L_ERROR;
        end else if (w_byte_valid) begin
          w_len      = w_len_full;
          w_word_idx = '0;
          w_byte_idx = '0;
          if (w_len_full > MAX_LEN) begin
            w_ld_next = L_ERROR;
          end else if (w_len_full == 16'd0) begin
            w_ld_next = L_DONE;
          end else begin
            w_ld_next = L_DATA;
          end
        end
      end
      L_DATA: begin
        if (w_frame_err) begin
          w_ld_next = L_ERROR;
        end else if (w_byte_valid) begin
          w_byte_idx = r_byte_idx + 2'd1;
          unique case (r_byte_idx)
            2'd0: w_word[7:0]   = r_shift;
            2'd1: w_word[15:8]  = r_shift;
            2'd2: w_word[23:16] = r_shift;
            default: begin
              // Lane 3 goes straight into the write word.
              w_we       = 1'b1;
              w_wdata    = {r_shift, r_word};
              w_waddr    = ADDR_W'({r_word_idx, 2'b00});
              w_word_idx = r_word_idx + 16'd1;
              if (r_word_idx + 16'd1 == r_len) begin
                w_ld_next = L_DONE;
              end
            end
          endcase
        end
      end
      L_DONE: begin
        w_ld_next = L_DONE;
      end
      L_ERROR: begin
        w_ld_next = L_ERROR;
      end
      default: begin
        w_ld_next = L_ERROR;
      end
    endcase
  end

  assign rom_we    = r_we;
  assign rom_waddr = r_waddr;
  assign rom_wdata = r_wdata;

  // The final strobe is issued in the first L_DONE cycle, so the
  // release waits one more cycle behind it.
  assign cpu_enable = (r_ld_state == L_DONE) && !r_we;
  assign busy       = (r_ld_state == L_LEN1) ||
                      (r_ld_state == L_DATA);
  assign error      = (r_ld_state == L_ERROR);

endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: directed vectors for uart_rom_loader
// (CLKS_PER_BIT=16, MAX_WORDS=4) plus hand-written corner sequences.
module tb_uart_rom_loader;

  localparam int CPB = 16;

  logic        clock;
  logic        reset;
  logic        uart_rx;
  logic        rom_we;
  logic [31:0] rom_waddr;
  logic [31:0] rom_wdata;
  logic        cpu_enable;
  logic        busy;
  logic        error;

  uart_rom_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS(4),
    .ADDR_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .uart_rx(uart_rx),
    .rom_we(rom_we),
    .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata),
    .cpu_enable(cpu_enable),
    .busy(busy),
    .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int          en_cyc = -1;
  logic        prev_en = 1'b0;

  always @(negedge clock) begin
    if (rom_we) begin
      wa_q.push_back(rom_waddr);
      wd_q.push_back(rom_wdata);
      wc_q.push_back(cyc);
    end
    if (cpu_enable && !prev_en) en_cyc = cyc;
    prev_en = cpu_enable;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop;
    tick(CPB);
    uart_rx = 1'b1;
    tick(CPB);
  endtask

  task automatic do_reset();
    uart_rx = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10 * CPB);
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_we"}, 32'(rom_we), 32'd0);
    chk({nm, "_addr"}, rom_waddr, 32'd0);
    chk({nm, "_data"}, rom_wdata, 32'd0);
    chk({nm, "_en"}, 32'(cpu_enable), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_err"}, 32'(error), 32'd0);
  endtask

  typedef struct {
    int               n;
    logic [159:0]     b;
    int               nw;
    logic [3:0][31:0] d;
    logic             en;
    logic             err;
  } vec_t;

  vec_t v[6];

  initial begin
    logic [159:0] bb;
    logic [7:0]   by;
    int           base;
    int           nwr;
    string        nm;

    v[0].n = 10;
    v[0].b = 160'h0200_1305_1000_6F00_0000;
    v[0].nw = 2;
    v[0].d = {32'h0, 32'h0, 32'h0000006F, 32'h00100513};
    v[0].en = 1'b1;
    v[0].err = 1'b0;

    v[1].n = 2;
    v[1].b = 160'h0000;
    v[1].nw = 0;
    v[1].d = '0;
    v[1].en = 1'b1;
    v[1].err = 1'b0;

    v[2].n = 10;
    v[2].b = 160'h0500_1122_3344_5566_7788;
    v[2].nw = 0;
    v[2].d = '0;
    v[2].en = 1'b0;
    v[2].err = 1'b1;

    v[3].n = 10;
    v[3].b = 160'h0100_EFBE_ADDE_1234_5678;
    v[3].nw = 1;
    v[3].d = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
    v[3].en = 1'b1;
    v[3].err = 1'b0;

    v[4].n = 18;
    v[4].b = 160'h0400_0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
    v[4].nw = 4;
    v[4].d = {32'h0F0E0D0C, 32'h0B0A0908,
              32'h07060504, 32'h03020100};
    v[4].en = 1'b1;
    v[4].err = 1'b0;

    v[5].n = 2;
    v[5].b = 160'h0001;
    v[5].nw = 0;
    v[5].d = '0;
    v[5].en = 1'b0;
    v[5].err = 1'b1;

    uart_rx = 1'b1;
    reset = 1'b1;
    tick(3);
    chk_idle_outs("reset");
    reset = 1'b0;
    tick(10 * CPB);

    // ---------------- table-driven images ----------------
    for (int i = 0; i < 6; i++) begin
      nm = $sformatf("vec%0d", i);
      do_reset();
      base = wa_q.size();
      bb = v[i].b;
      for (int k = 0; k < v[i].n; k++) begin
        by = bb[8*(v[i].n-1-k) +: 8];
        send_byte(by, 1'b1);
      end
      tick(4 * CPB);
      nwr = wa_q.size() - base;
      chk({nm, "_nwrites"}, 32'(nwr), 32'(v[i].nw));
      for (int k = 0; k < v[i].nw && k < nwr; k++) begin
        chk($sformatf("%s_addr%0d", nm, k),
            wa_q[base+k], 32'(4 * k));
        chk($sformatf("%s_data%0d", nm, k),
            wd_q[base+k], v[i].d[k]);
      end
      chk({nm, "_en"}, 32'(cpu_enable), 32'(v[i].en));
      chk({nm, "_err"}, 32'(error), 32'(v[i].err));
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      if (v[i].nw > 0 && nwr > 0 && v[i].en) begin
        chk({nm, "_en_lat"}, 32'(en_cyc),
            32'(wc_q[wa_q.size()-1] + 1));
      end
    end

    // ---------------- len 0: release timing ----------------
    do_reset();
    base = wa_q.size();
    send_byte(8'h00, 1'b1);
    chk("len0_busy", 32'(busy), 32'd1);
    uart_rx = 1'b0;
    tick(9 * CPB);
    chk("len0_en_early", 32'(cpu_enable), 32'd0);
    uart_rx = 1'b1;
    tick(CPB);
    chk("len0_en_after_stop", 32'(cpu_enable), 32'd1);
    chk("len0_nwrites", 32'(wa_q.size() - base), 32'd0);

    // ---------------- start-bit glitch ----------------
    do_reset();
    base = wa_q.size();
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(12 * CPB);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_err", 32'(error), 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    tick(2 * CPB);
    chk("glitch_nwrites", 32'(wa_q.size() - base), 32'd1);
    if (wa_q.size() > base) begin
      chk("glitch_addr", wa_q[base], 32'h0);
      chk("glitch_data", wd_q[base], 32'hDEADBEEF);
    end
    chk("glitch_en", 32'(cpu_enable), 32'd1);

    // ---------------- framing error ----------------
    do_reset();
    base = wa_q.size();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    tick(2 * CPB);
    chk("frame_err", 32'(error), 32'd1);
    chk("frame_busy", 32'(busy), 32'd0);
    chk("frame_en", 32'(cpu_enable), 32'd0);
    chk("frame_nwrites", 32'(wa_q.size() - base), 32'd0);

    // ---------------- reset mid-image ----------------
    do_reset();
    base = wa_q.size();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(8'h11, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    chk("mid_pre_busy", 32'(busy), 32'd1);
    chk("mid_pre_nwrites", 32'(wa_q.size() - base), 32'd1);
    reset = 1'b1;
    tick(1);
    chk_idle_outs("mid_in_reset");
    reset = 1'b0;
    tick(10 * CPB);
    base = wa_q.size();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    tick(2 * CPB);
    chk("mid_nwrites", 32'(wa_q.size() - base), 32'd1);
    if (wa_q.size() > base) begin
      chk("mid_addr", wa_q[base], 32'h0);
      chk("mid_data", wd_q[base], 32'h44332211);
    end
    chk("mid_en", 32'(cpu_enable), 32'd1);
    chk("mid_err", 32'(error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
